// File: rtl/bluetile_pkg.sv
// Shared definitions for the bluetile request/response stream: opcodes,
// response codes, header field positions and the responder state encoding.
package bluetile_pkg;

  // Request opcodes carried in the header flit
  localparam logic [7:0] OPC_WRITE = 8'h01;
  localparam logic [7:0] OPC_READ  = 8'h02;

  // Response codes placed in the top byte of a response header
  localparam logic [7:0] RSP_WACK = 8'h81;
  localparam logic [7:0] RSP_RHDR = 8'h82;
  localparam logic [7:0] RSP_ERR  = 8'hFF;

  // Header flit layout: [31:24] opcode, [23:16] length, [15:0] word address
  localparam int HDR_OPC_HI  = 31;
  localparam int HDR_OPC_LO  = 24;
  localparam int HDR_LEN_HI  = 23;
  localparam int HDR_LEN_LO  = 16;
  localparam int HDR_ADDR_HI = 15;
  localparam int HDR_ADDR_LO = 0;

  // Responder packet-processing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_HDR,
    ST_RD_FETCH,
    ST_RD_SEND,
    ST_ERR
  } state_t;

  // Assemble a response header flit from its code, length and address fields
  function automatic logic [31:0] make_hdr(input logic [7:0]  code,
                                           input logic [7:0]  len,
                                           input logic [15:0] addr);
    return {code, len, addr};
  endfunction

endpackage

// File: rtl/bluetile_resp_ram.sv
// Single-port synchronous scratch RAM for the bluetile responder.
// Writes land on the clock edge; reads are registered, so data appears one
// cycle after the address is presented with rd_en high, and then holds until
// the next read.
module bluetile_resp_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [0:DEPTH-1];

  // Memory array write plus registered read; rdata is only refreshed on a read
  // so the responder can hold a fetched word steady under backpressure.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bluetile_mem_responder.sv
// Far-end memory target for a bluetile tile: consumes request flits, serves
// single-header WRITE and READ packets out of a word-addressed scratch RAM and
// returns response flits. Packets are handled strictly one at a time.
// ADDR_W is expected to be at most 16, the width of the header address field.
module bluetile_mem_responder
  import bluetile_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] req_DIN,
  input  logic        req_valid,
  output logic        req_accept,
  output logic [31:0] rsp_DOUT,
  input  logic        rsp_canaccept,
  output logic        rsp_commit
);

  state_t             state;
  logic [7:0]         len_q;
  logic [15:0]        addr_q;
  logic [7:0]         count_q;
  logic [31:0]        hdr_q;
  logic               rsp_pending;

  logic               req_fire;
  logic [8:0]         count_next;
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_wr_en;
  logic               ram_rd_en;
  logic [31:0]        ram_rdata;

  logic [7:0]         hdr_opc;
  logic [7:0]         hdr_len;
  logic [15:0]        hdr_addr;

  assign hdr_opc  = req_DIN[HDR_OPC_HI:HDR_OPC_LO];
  assign hdr_len  = req_DIN[HDR_LEN_HI:HDR_LEN_LO];
  assign hdr_addr = req_DIN[HDR_ADDR_HI:HDR_ADDR_LO];

  assign req_fire   = req_valid && req_accept;
  assign rsp_commit = rsp_pending && rsp_canaccept;

  // count is widened by one bit so that N=255 terminates without wrapping
  assign count_next = {1'b0, count_q} + 9'd1;

  // Word k of a packet lives at (A+k) mod depth; the truncating add wraps it
  assign ram_addr  = addr_q[ADDR_W-1:0] + ADDR_W'(count_q);
  assign ram_wr_en = (state == ST_WR_DATA) && req_fire;
  assign ram_rd_en = (state == ST_RD_FETCH);

  // While sending read payload the fetched RAM word is the response flit;
  // every other response is the header register built on entry to the state
  assign rsp_DOUT = (state == ST_RD_SEND) ? ram_rdata : hdr_q;

  bluetile_resp_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (CLK),
    .wr_en (ram_wr_en),
    .rd_en (ram_rd_en),
    .addr  (ram_addr),
    .wdata (req_DIN),
    .rdata (ram_rdata)
  );

  // Packet FSM: sequences header decode, write data, read fetch/send and the
  // response flits, with req_accept and the pending flag held as registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      req_accept  <= 1'b0;
      rsp_pending <= 1'b0;
      hdr_q       <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      count_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_accept <= 1'b1;
          if (req_fire) begin
            len_q   <= hdr_len;
            addr_q  <= hdr_addr;
            count_q <= '0;
            case (hdr_opc)
              OPC_WRITE: begin
                if (hdr_len != 8'd0) begin
                  state <= ST_WR_DATA;
                end else begin
                  state       <= ST_WR_ACK;
                  req_accept  <= 1'b0;
                  rsp_pending <= 1'b1;
                  hdr_q       <= make_hdr(RSP_WACK, hdr_len, hdr_addr);
                end
              end
              OPC_READ: begin
                state       <= ST_RD_HDR;
                req_accept  <= 1'b0;
                rsp_pending <= 1'b1;
                hdr_q       <= make_hdr(RSP_RHDR, hdr_len, hdr_addr);
              end
              default: begin
                state       <= ST_ERR;
                req_accept  <= 1'b0;
                rsp_pending <= 1'b1;
                hdr_q       <= make_hdr(RSP_ERR, 8'h00, hdr_addr);
              end
            endcase
          end
        end

        ST_WR_DATA: begin
          if (req_fire) begin
            count_q <= count_next[7:0];
            if (count_next == {1'b0, len_q}) begin
              state       <= ST_WR_ACK;
              req_accept  <= 1'b0;
              rsp_pending <= 1'b1;
              hdr_q       <= make_hdr(RSP_WACK, len_q, addr_q);
            end
          end
        end

        ST_WR_ACK: begin
          if (rsp_commit) begin
            state       <= ST_IDLE;
            rsp_pending <= 1'b0;
            req_accept  <= 1'b1;
          end
        end

        ST_RD_HDR: begin
          if (rsp_commit) begin
            rsp_pending <= 1'b0;
            if (len_q != 8'd0) begin
              state <= ST_RD_FETCH;
            end else begin
              state      <= ST_IDLE;
              req_accept <= 1'b1;
            end
          end
        end

        ST_RD_FETCH: begin
          state       <= ST_RD_SEND;
          rsp_pending <= 1'b1;
        end

        ST_RD_SEND: begin
          if (rsp_commit) begin
            count_q     <= count_next[7:0];
            rsp_pending <= 1'b0;
            if (count_next < {1'b0, len_q}) begin
              state <= ST_RD_FETCH;
            end else begin
              state      <= ST_IDLE;
              req_accept <= 1'b1;
            end
          end
        end

        ST_ERR: begin
          if (rsp_commit) begin
            state       <= ST_IDLE;
            rsp_pending <= 1'b0;
            req_accept  <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          req_accept  <= 1'b0;
          rsp_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bluetile_mem_responder.sv
// Directed bench for bluetile_mem_responder: drives request flits and checks
// response flits, their exact cycle timing and the handshake outputs against
// hand-computed values.
module tb_bluetile_mem_responder;

  logic        CLK;
  logic        RST;
  logic [31:0] req_DIN;
  logic        req_valid;
  logic        req_accept;
  logic [31:0] rsp_DOUT;
  logic        rsp_canaccept;
  logic        rsp_commit;

  int n_checks = 0;
  int n_fail   = 0;

  bluetile_mem_responder #(
    .ADDR_W (10)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_DIN       (req_DIN),
    .req_valid     (req_valid),
    .req_accept    (req_accept),
    .rsp_DOUT      (rsp_DOUT),
    .rsp_canaccept (rsp_canaccept),
    .rsp_commit    (rsp_commit)
  );

  // Free-running clock, 10 time units per period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one observed value with its expected value and log any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then let outputs settle
  task automatic applyStimulus(input logic rst, input logic valid,
                               input logic [31:0] din, input logic can);
    @(negedge CLK);
    RST           = rst;
    req_valid     = valid;
    req_DIN       = din;
    rsp_canaccept = can;
    #1;
  endtask

  // Present a request flit until it is taken, with a bounded wait
  task automatic sendFlit(input string tag, input logic [31:0] data);
    int waited;
    waited = 0;
    applyStimulus(1'b0, 1'b1, data, 1'b1);
    while (!req_accept && waited < 20) begin
      applyStimulus(1'b0, 1'b1, data, 1'b1);
      waited++;
    end
    checkOutput({tag, "_accept"}, {31'b0, req_accept}, 32'd1);
  endtask

  // Expect a response commit after exactly 'delay' quiet cycles
  task automatic expectRsp(input string tag, input logic [31:0] expected,
                           input int delay);
    for (int i = 0; i < delay; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput({tag, "_quiet"}, {31'b0, rsp_commit}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput({tag, "_commit"}, {31'b0, rsp_commit}, 32'd1);
    checkOutput({tag, "_data"}, rsp_DOUT, expected);
    checkOutput({tag, "_noacc"}, {31'b0, req_accept}, 32'd0);
  endtask

  // Expect the responder back in IDLE: nothing committing, requests accepted
  task automatic expectIdle(input string tag);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput({tag, "_nocommit"}, {31'b0, rsp_commit}, 32'd0);
    checkOutput({tag, "_accept"}, {31'b0, req_accept}, 32'd1);
  endtask

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    RST           = 1'b1;
    req_valid     = 1'b0;
    req_DIN       = 32'h0;
    rsp_canaccept = 1'b0;

    // Reset and its output values
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_accept", {31'b0, req_accept}, 32'd0);
    checkOutput("rst_commit", {31'b0, rsp_commit}, 32'd0);
    checkOutput("rst_dout", rsp_DOUT, 32'h0);
    expectIdle("post_rst");

    // Write 3 words at 0x0010, then read them back
    sendFlit("wr3_hdr", 32'h0103_0010);
    sendFlit("wr3_d0", 32'h0000_000A);
    sendFlit("wr3_d1", 32'h0000_000B);
    sendFlit("wr3_d2", 32'h0000_000C);
    expectRsp("wr3_ack", 32'h8103_0010, 0);
    expectIdle("wr3_done");

    sendFlit("rd3_hdr", 32'h0203_0010);
    expectRsp("rd3_rhdr", 32'h8203_0010, 0);
    expectRsp("rd3_w0", 32'h0000_000A, 1);
    expectRsp("rd3_w1", 32'h0000_000B, 1);
    expectRsp("rd3_w2", 32'h0000_000C, 1);
    expectIdle("rd3_done");

    // Zero-length write and read
    sendFlit("wr0_hdr", 32'h0100_0005);
    expectRsp("wr0_ack", 32'h8100_0005, 0);
    expectIdle("wr0_done");

    sendFlit("rd0_hdr", 32'h0200_0005);
    expectRsp("rd0_rhdr", 32'h8200_0005, 0);
    expectIdle("rd0_done");

    // Bad opcode, then the next flit is a fresh header
    sendFlit("bad_hdr", 32'h7E04_1234);
    expectRsp("bad_err", 32'hFF00_1234, 0);
    expectIdle("bad_done");
    sendFlit("after_bad_hdr", 32'h0201_0010);
    expectRsp("after_bad_rhdr", 32'h8201_0010, 0);
    expectRsp("after_bad_w0", 32'h0000_000A, 1);
    expectIdle("after_bad_done");

    // Address wrap across the top of the 1K-word memory
    sendFlit("wrap_wr_hdr", 32'h0102_03FF);
    sendFlit("wrap_wr_d0", 32'h0000_0011);
    sendFlit("wrap_wr_d1", 32'h0000_0022);
    expectRsp("wrap_wr_ack", 32'h8102_03FF, 0);
    expectIdle("wrap_wr_done");

    sendFlit("wrap_rd_hdr", 32'h0202_03FF);
    expectRsp("wrap_rd_rhdr", 32'h8202_03FF, 0);
    expectRsp("wrap_rd_w0", 32'h0000_0011, 1);
    expectRsp("wrap_rd_w1", 32'h0000_0022, 1);
    expectIdle("wrap_rd_done");

    sendFlit("wrap_zero_hdr", 32'h0201_0000);
    expectRsp("wrap_zero_rhdr", 32'h8201_0000, 0);
    expectRsp("wrap_zero_w0", 32'h0000_0022, 1);
    expectIdle("wrap_zero_done");

    // Backpressure in the middle of a 4-word read
    sendFlit("bp_wr_hdr", 32'h0104_0020);
    sendFlit("bp_wr_d0", 32'h0000_1000);
    sendFlit("bp_wr_d1", 32'h0000_2000);
    sendFlit("bp_wr_d2", 32'h0000_3000);
    sendFlit("bp_wr_d3", 32'h0000_4000);
    expectRsp("bp_wr_ack", 32'h8104_0020, 0);
    expectIdle("bp_wr_done");

    sendFlit("bp_rd_hdr", 32'h0204_0020);
    expectRsp("bp_rd_rhdr", 32'h8204_0020, 0);
    expectRsp("bp_rd_w0", 32'h0000_1000, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("bp_fetch_quiet", {31'b0, rsp_commit}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("bp_hold_commit", {31'b0, rsp_commit}, 32'd0);
      checkOutput("bp_hold_data", rsp_DOUT, 32'h0000_2000);
    end
    expectRsp("bp_rd_w1", 32'h0000_2000, 0);
    expectRsp("bp_rd_w2", 32'h0000_3000, 1);
    expectRsp("bp_rd_w3", 32'h0000_4000, 1);
    expectIdle("bp_rd_done");

    // Reset after the first of three write data flits
    sendFlit("rstw_hdr", 32'h0103_0040);
    sendFlit("rstw_d0", 32'h0000_0005);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rstw_accept", {31'b0, req_accept}, 32'd0);
    checkOutput("rstw_commit", {31'b0, rsp_commit}, 32'd0);
    checkOutput("rstw_dout", rsp_DOUT, 32'h0);
    expectIdle("rstw_idle");

    sendFlit("rstw_rd_hdr", 32'h0201_0040);
    expectRsp("rstw_rd_rhdr", 32'h8201_0040, 0);
    expectRsp("rstw_rd_w0", 32'h0000_0005, 1);
    expectIdle("rstw_rd_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
